// File: rtl/interrupt_entry_sequencer.sv
// Asynchronous interrupt entry: requests a precise commit halt, then emits one
// flush, one CSR trap-entry write and one fetch redirect per accepted interrupt.
module interrupt_entry_sequencer (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        int_i,
  input  logic [3:0]  int_type_i,
  input  logic [1:0]  new_mode_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] stvec_i,
  output logic        commit_req_o,
  input  logic        commit_ack_i,
  input  logic [31:0] commit_pc_i,
  output logic        flush_o,
  output logic        trap_we_o,
  output logic [1:0]  trap_mode_o,
  output logic [31:0] trap_cause_o,
  output logic [31:0] trap_epc_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_UPDATE   = 3'd3,
    ST_REDIRECT = 3'd4,
    ST_COOLDOWN = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        accept_s;
  logic [31:0] tvec_sel_s;

  logic        commit_req_q, commit_req_d;
  logic        flush_q, flush_d;
  logic        trap_we_q, trap_we_d;
  logic        redirect_q, redirect_d;
  logic        busy_q, busy_d;

  logic [1:0]  mode_q, mode_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] target_q, target_d;

  // Handler address: vectored mode adds 4*cause to the aligned base, wrapping at 32 bits.
  function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [3:0] cause);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (tvec[1:0] == 2'b01) begin
      trap_target = base + {26'b0, cause, 2'b00};
    end else begin
      trap_target = base;
    end
  endfunction

  // Trap vector chosen by the target privilege.
  always_comb begin
    if (new_mode_i == 2'b11) begin
      tvec_sel_s = mtvec_i;
    end else begin
      tvec_sel_s = stvec_i;
    end
  end

  // Next-state logic; an ack in REQ wins over a simultaneous withdrawal.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (int_i) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (commit_ack_i) begin
          state_d  = ST_FLUSH;
          accept_s = 1'b1;
        end else if (!int_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_FLUSH:    state_d = ST_UPDATE;
      ST_UPDATE:   state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_COOLDOWN;
      ST_COOLDOWN: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave the block registered.
  always_comb begin
    commit_req_d = (state_d == ST_REQ);
    flush_d      = (state_d == ST_FLUSH);
    trap_we_d    = (state_d == ST_UPDATE);
    redirect_d   = (state_d == ST_REDIRECT);
    busy_d       = (state_d != ST_IDLE);
  end

  // Trap payload captured only on acceptance; held otherwise.
  always_comb begin
    mode_d   = mode_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    target_d = target_q;
    if (accept_s) begin
      mode_d   = new_mode_i;
      cause_d  = {1'b1, 27'b0, int_type_i};
      epc_d    = commit_pc_i;
      target_d = trap_target(tvec_sel_s, int_type_i);
    end else begin
      mode_d   = mode_q;
      cause_d  = cause_q;
      epc_d    = epc_q;
      target_d = target_q;
    end
  end

  // State, strobe and payload registers with synchronous reset.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q      <= ST_IDLE;
      commit_req_q <= 1'b0;
      flush_q      <= 1'b0;
      trap_we_q    <= 1'b0;
      redirect_q   <= 1'b0;
      busy_q       <= 1'b0;
      mode_q       <= 2'b00;
      cause_q      <= 32'h0000_0000;
      epc_q        <= 32'h0000_0000;
      target_q     <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      commit_req_q <= commit_req_d;
      flush_q      <= flush_d;
      trap_we_q    <= trap_we_d;
      redirect_q   <= redirect_d;
      busy_q       <= busy_d;
      mode_q       <= mode_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      target_q     <= target_d;
    end
  end

  assign commit_req_o  = commit_req_q;
  assign flush_o       = flush_q;
  assign trap_we_o     = trap_we_q;
  assign redirect_o    = redirect_q;
  assign busy_o        = busy_q;
  assign trap_mode_o   = mode_q;
  assign trap_cause_o  = cause_q;
  assign trap_epc_o    = epc_q;
  assign redirect_pc_o = target_q;

endmodule

// File: tb/tb_interrupt_entry_sequencer.sv
// Self-checking bench: a cycle-timed reference model (ack cycle + offsets) compared
// against the sequencer under directed scenarios and random stimulus.
module tb_interrupt_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst, int_v, ack;
  logic [3:0]  itype;
  logic [1:0]  nmode;
  logic [31:0] mtvec, stvec, cpc;
  logic        commit_req_o, flush_o, trap_we_o, redirect_o, busy_o;
  logic [1:0]  trap_mode_o;
  logic [31:0] trap_cause_o, trap_epc_o, redirect_pc_o;

  interrupt_entry_sequencer dut (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .int_i(int_v), .int_type_i(itype),
    .new_mode_i(nmode), .mtvec_i(mtvec), .stvec_i(stvec),
    .commit_req_o(commit_req_o), .commit_ack_i(ack), .commit_pc_i(cpc),
    .flush_o(flush_o), .trap_we_o(trap_we_o), .trap_mode_o(trap_mode_o),
    .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_a   = -1000;   // cycle in which the last ack was accepted
  bit m_req = 1'b0;    // model: a commit request is outstanding this cycle
  logic [1:0]  e_mode;
  logic [31:0] e_cause, e_epc, e_target;

  function automatic logic [31:0] ref_target(input logic [31:0] tv, input logic [3:0] c);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
    if (tv % 4 == 1) return base + 32'(c) * 32'd4;
    return base;
  endfunction

  // Expected {commit_req, flush, trap_we, redirect, busy} for the current cycle.
  function automatic logic [4:0] exp_strobes();
    bit seq;
    seq = (cyc >= m_a + 1) && (cyc <= m_a + 4);
    return {m_req, cyc == m_a + 1, cyc == m_a + 2, cyc == m_a + 3, m_req || seq};
  endfunction

  task automatic tick();
    bit seq;
    seq = (cyc >= m_a + 1) && (cyc <= m_a + 4);
    if (rst) begin
      m_req = 1'b0; m_a = -1000;
      e_mode = 2'b00; e_cause = 32'd0; e_epc = 32'd0; e_target = 32'd0;
    end else if (m_req && ack) begin
      m_req = 1'b0; m_a = cyc;
      e_mode = nmode; e_cause = 32'h8000_0000 + 32'(itype); e_epc = cpc;
      e_target = ref_target((nmode == 2'b11) ? mtvec : stvec, itype);
    end else if (m_req) begin
      m_req = int_v;
    end else begin
      m_req = int_v && !seq;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++;
    if ({commit_req_o, flush_o, trap_we_o, redirect_o, busy_o, trap_mode_o,
         trap_cause_o, trap_epc_o, redirect_pc_o} !== 103'd0) begin
      bad++; $display("FAIL reset_state got=%b/%h/%h/%h/%h want all zero",
                      {commit_req_o, flush_o, trap_we_o, redirect_o, busy_o},
                      trap_mode_o, trap_cause_o, trap_epc_o, redirect_pc_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_direct_m();
    int a, f_at = -1, w_at = -1, r_at = -1;
    logic [31:0] cause_w = 32'd0, epc_w = 32'd0, pc_r = 32'd0;
    mtvec = 32'h8000_0000; stvec = 32'h0000_4000; itype = 4'd7; nmode = 2'b11;
    cpc = 32'h0000_1234; int_v = 1'b1;
    tick();
    ack = 1'b1; a = cyc; tick(); ack = 1'b0; int_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({commit_req_o, flush_o, trap_we_o, redirect_o, busy_o} !== exp_strobes()) begin
        bad++; $display("FAIL direct_strobes cyc=%0d got=%b want=%b", cyc,
                        {commit_req_o, flush_o, trap_we_o, redirect_o, busy_o}, exp_strobes());
      end
      if (flush_o === 1'b1) f_at = cyc;
      if (trap_we_o === 1'b1) begin w_at = cyc; cause_w = trap_cause_o; epc_w = trap_epc_o; end
      if (redirect_o === 1'b1) begin r_at = cyc; pc_r = redirect_pc_o; end
      if (i < 5) tick();
    end
    total++;
    if ({f_at - a, w_at - a, r_at - a} !== {32'sd1, 32'sd2, 32'sd3}) begin
      bad++; $display("FAIL direct_timing got=%0d/%0d/%0d want 1/2/3", f_at - a, w_at - a, r_at - a);
    end
    total++;
    if ({cause_w, epc_w, pc_r} !== {32'h8000_0007, 32'h0000_1234, 32'h8000_0000}) begin
      bad++; $display("FAIL direct_values got=%h/%h/%h want 80000007/00001234/80000000",
                      cause_w, epc_w, pc_r);
    end
  endtask

  task automatic test_vectored_s();
    logic [1:0] mode_w = 2'b00;
    logic [31:0] cause_w = 32'd0, pc_r = 32'd0;
    stvec = 32'h0000_1001; mtvec = 32'h8000_0000; itype = 4'd9; nmode = 2'b01;
    cpc = $urandom; int_v = 1'b1;
    tick(); ack = 1'b1; tick(); ack = 1'b0; int_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({commit_req_o, flush_o, trap_we_o, redirect_o, busy_o} !== exp_strobes()) begin
        bad++; $display("FAIL vect_strobes cyc=%0d got=%b want=%b", cyc,
                        {commit_req_o, flush_o, trap_we_o, redirect_o, busy_o}, exp_strobes());
      end
      if (trap_we_o === 1'b1) begin mode_w = trap_mode_o; cause_w = trap_cause_o; end
      if (redirect_o === 1'b1) pc_r = redirect_pc_o;
      tick();
    end
    total++;
    if ({mode_w, cause_w, pc_r} !== {2'b01, 32'h8000_0009, 32'h0000_1024}) begin
      bad++; $display("FAIL vect_values got=%b/%h/%h want 01/80000009/00001024", mode_w, cause_w, pc_r);
    end
  endtask

  task automatic test_withdraw();
    int strobes = 0;
    int_v = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    int_v = 1'b0; tick();
    total++;
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL withdraw_busy got=%b want=0", busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({commit_req_o, flush_o, trap_we_o, redirect_o, busy_o} !== exp_strobes()) begin
        bad++; $display("FAIL withdraw_strobes cyc=%0d got=%b want=%b", cyc,
                        {commit_req_o, flush_o, trap_we_o, redirect_o, busy_o}, exp_strobes());
      end
      strobes += int'(flush_o) + int'(trap_we_o) + int'(redirect_o);
      tick();
    end
    total++;
    if (strobes !== 0) begin
      bad++; $display("FAIL withdraw_nostrobe got=%0d want=0", strobes);
    end
  endtask

  task automatic test_ack_withdraw();
    mtvec = 32'h2000_0001; itype = 4'd3; nmode = 2'b11; cpc = 32'hCAFE_0010; int_v = 1'b1;
    tick();
    ack = 1'b1; int_v = 1'b0; tick();
    ack = 1'b0; itype = 4'd11; cpc = 32'h0BAD_0000; mtvec = 32'h0000_0000;
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({commit_req_o, flush_o, trap_we_o, redirect_o, busy_o} !== exp_strobes()) begin
        bad++; $display("FAIL ackwd_strobes cyc=%0d got=%b want=%b", cyc,
                        {commit_req_o, flush_o, trap_we_o, redirect_o, busy_o}, exp_strobes());
      end
      if (trap_we_o === 1'b1) begin
        total++;
        if ({trap_mode_o, trap_cause_o, trap_epc_o} !== {2'b11, 32'h8000_0003, 32'hCAFE_0010}) begin
          bad++; $display("FAIL ackwd_csr got=%b/%h/%h want 11/80000003/cafe0010",
                          trap_mode_o, trap_cause_o, trap_epc_o);
        end
      end
      if (redirect_o === 1'b1) begin
        total++;
        if (redirect_pc_o !== 32'h2000_000C) begin
          bad++; $display("FAIL ackwd_pc got=%h want=2000000c", redirect_pc_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int redirs = 0;
    itype = 4'd5; nmode = 2'b11; mtvec = 32'h0000_8000; cpc = 32'h0000_0444; int_v = 1'b1;
    tick(); ack = 1'b1; tick(); ack = 1'b0; int_v = 1'b0; tick();
    total++;
    if (trap_we_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_update got=%b want=1", trap_we_o);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({commit_req_o, flush_o, trap_we_o, redirect_o, busy_o, trap_mode_o,
         trap_cause_o, trap_epc_o, redirect_pc_o} !== 103'd0) begin
      bad++; $display("FAIL rstmid_zero got=%b/%h/%h/%h want all zero",
                      {commit_req_o, flush_o, trap_we_o, redirect_o, busy_o},
                      trap_cause_o, trap_epc_o, redirect_pc_o);
    end
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({commit_req_o, flush_o, trap_we_o, redirect_o, busy_o} !== exp_strobes()) begin
        bad++; $display("FAIL rstmid_strobes cyc=%0d got=%b want=%b", cyc,
                        {commit_req_o, flush_o, trap_we_o, redirect_o, busy_o}, exp_strobes());
      end
      redirs += int'(redirect_o);
    end
    ack = 1'b0;
    total++;
    if (redirs !== 0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_quiet got=%0d/%b want 0/0", redirs, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int t, r_at = -1, req2 = -1, nf = 0, nw = 0, nr = 0;
    itype = 4'd1; nmode = 2'b01; stvec = 32'h0000_0201; cpc = 32'h0000_0100;
    t = cyc; int_v = 1'b1;
    tick(); ack = 1'b1; tick(); ack = 1'b0;
    for (int i = 0; i < 14; i++) begin
      total++;
      if ({commit_req_o, flush_o, trap_we_o, redirect_o, busy_o} !== exp_strobes()) begin
        bad++; $display("FAIL b2b_strobes cyc=%0d got=%b want=%b", cyc,
                        {commit_req_o, flush_o, trap_we_o, redirect_o, busy_o}, exp_strobes());
      end
      if (redirect_o === 1'b1 && r_at < 0) r_at = cyc;
      if (commit_req_o === 1'b1 && cyc > t + 2 && req2 < 0) begin
        req2 = cyc; ack = 1'b1; cpc = 32'h0000_0200;
      end else begin
        ack = 1'b0;
      end
      if (i == 10) int_v = 1'b0;
      nf += int'(flush_o); nw += int'(trap_we_o); nr += int'(redirect_o);
      tick();
    end
    total++;
    if (r_at - t !== 4 || req2 - t !== 7) begin
      bad++; $display("FAIL b2b_timing got=%0d/%0d want 4/7", r_at - t, req2 - t);
    end
    total++;
    if (nf !== 2 || nw !== 2 || nr !== 2) begin
      bad++; $display("FAIL b2b_counts got=%0d/%0d/%0d want 2/2/2", nf, nw, nr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      int_v = ($urandom_range(0, 3) != 0);
      ack   = ($urandom_range(0, 2) == 0);
      itype = 4'($urandom);
      nmode = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
      mtvec = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      stvec = {$urandom_range(0, 65535), 14'($urandom), 2'($urandom_range(0, 3))};
      cpc   = $urandom;
      tick();
      total++;
      if ({commit_req_o, flush_o, trap_we_o, redirect_o, busy_o} !== exp_strobes()) begin
        bad++; $display("FAIL rand_strobes cyc=%0d got=%b want=%b", cyc,
                        {commit_req_o, flush_o, trap_we_o, redirect_o, busy_o}, exp_strobes());
      end
      if (trap_we_o === 1'b1) begin
        total++;
        if ({trap_mode_o, trap_cause_o, trap_epc_o} !== {e_mode, e_cause, e_epc}) begin
          bad++; $display("FAIL rand_csr cyc=%0d got=%b/%h/%h want=%b/%h/%h", cyc,
                          trap_mode_o, trap_cause_o, trap_epc_o, e_mode, e_cause, e_epc);
        end
      end
      if (redirect_o === 1'b1) begin
        total++;
        if (redirect_pc_o !== e_target) begin
          bad++; $display("FAIL rand_pc cyc=%0d got=%h want=%h", cyc, redirect_pc_o, e_target);
        end
      end
    end
    rst = 1'b0; ack = 1'b0; int_v = 1'b0;
  endtask

  initial begin
    rst = 1'b1; int_v = 1'b0; ack = 1'b0; itype = 4'd0; nmode = 2'b00;
    mtvec = 32'd0; stvec = 32'd0; cpc = 32'd0;
    test_reset();
    test_direct_m();
    test_vectored_s();
    test_withdraw();
    test_ack_withdraw();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
